// File: rtl/ex_muldiv_if.sv
// Execute-stage handshake between the pipeline and the iterative RV32M multiply/divide unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
interface ex_muldiv_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start_i;
   logic [2:0]            funct3_i;
   logic [DATA_WIDTH-1:0] op_a_i;
   logic [DATA_WIDTH-1:0] op_b_i;
   logic [4:0]            rd_i;
   logic                  busy_o;
   logic                  done_o;
   logic [DATA_WIDTH-1:0] result_o;
   logic [4:0]            rd_o;

   modport master (
      output start_i, funct3_i, op_a_i, op_b_i, rd_i,
      input  busy_o, done_o, result_o, rd_o
   );

   modport slave (
      input  start_i, funct3_i, op_a_i, op_b_i, rd_i,
      output busy_o, done_o, result_o, rd_o
   );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle on operand magnitudes,
// with sign correction on the way out of CALC and divide special cases resolved at issue.
module ex_muldiv #(
   parameter int DATA_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush_i,
   ex_muldiv_if.slave bus
);
   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e       state_q, state_d;
   logic [5:0]   cnt_q, cnt_d;
   logic [2:0]   funct3_q, funct3_d;
   logic [4:0]   rd_q, rd_d;
   logic [4:0]   rd_out_q, rd_out_d;
   logic [W-1:0] opnd_q, opnd_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic         neg_q, neg_d;
   logic         rneg_q, rneg_d;
   logic [W-1:0] result_q, result_d;

   logic         is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
   logic [W-1:0] a_mag, b_mag;
   logic         div_zero, div_ovf, special;
   logic [W-1:0] special_val;

   logic [W:0]     mul_sum, div_trial;
   logic [2*W-1:0] step_acc, prod_fix;
   logic [W-1:0]   quo_fix, rem_fix, calc_result;

   // Issue-time decode of the op presented in execute
   assign is_div   = bus.funct3_i[2];
   assign is_rem   = bus.funct3_i[1];
   assign a_signed = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
                     (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
   assign b_signed = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
                     (bus.funct3_i == 3'b110);
   assign a_neg    = a_signed && bus.op_a_i[W-1];
   assign b_neg    = b_signed && bus.op_b_i[W-1];
   assign a_mag    = a_neg ? -bus.op_a_i : bus.op_a_i;
   assign b_mag    = b_neg ? -bus.op_b_i : bus.op_b_i;

   assign div_zero    = is_div && (bus.op_b_i == '0);
   assign div_ovf     = is_div && !bus.funct3_i[0] && (bus.op_a_i == MIN_NEG) && (bus.op_b_i == '1);
   assign special     = div_zero || div_ovf;
   assign special_val = div_zero ? (is_rem ? bus.op_a_i : '1) : (is_rem ? '0 : MIN_NEG);

   // Multiply shifts the product right; divide shifts {remainder, quotient} left
   assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign div_trial = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, opnd_q};
   assign step_acc  = funct3_q[2]
                    ? (div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                    : {div_trial[W-1:0], acc_q[W-2:0], 1'b1})
                    : {mul_sum, acc_q[W-1:1]};

   assign prod_fix = neg_q  ? -step_acc : step_acc;
   assign quo_fix  = neg_q  ? -step_acc[W-1:0] : step_acc[W-1:0];
   assign rem_fix  = rneg_q ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];

   always_comb begin
      calc_result = prod_fix[W-1:0];
      unique case (funct3_q)
         3'b001, 3'b010, 3'b011: calc_result = prod_fix[2*W-1:W];
         3'b100, 3'b101:         calc_result = quo_fix;
         3'b110, 3'b111:         calc_result = rem_fix;
         default:                calc_result = prod_fix[W-1:0];
      endcase
   end

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      rd_out_d = rd_out_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;

      if (flush_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  funct3_d = bus.funct3_i;
                  rd_d     = bus.rd_i;
                  neg_d    = a_neg ^ b_neg;
                  rneg_d   = a_neg;
                  if (special) begin
                     result_d = special_val;
                     rd_out_d = bus.rd_i;
                     state_d  = DONE;
                  end else begin
                     cnt_d   = '0;
                     acc_d   = {{W{1'b0}}, (is_div ? a_mag : b_mag)};
                     opnd_d  = is_div ? b_mag : a_mag;
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               acc_d = step_acc;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  result_d = calc_result;
                  rd_out_d = rd_q;
                  state_d  = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         funct3_q <= '0;
         rd_q     <= '0;
         rd_out_q <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         rd_out_q <= rd_out_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   // Stall is raised combinationally in the issue cycle
   assign bus.busy_o   = ((state_q == IDLE) && bus.start_i && !flush_i) || (state_q == CALC);
   assign bus.done_o   = (state_q == DONE);
   assign bus.result_o = result_q;
   assign bus.rd_o     = rd_out_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, multi-cycle corner sequences
// and randomized ops compared against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv;
   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_checks = 0;
   int   n_errors = 0;

   ex_muldiv_if #(.DATA_WIDTH(32)) bus ();

   ex_muldiv #(.DATA_WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp_res;
      int          exp_done_at;
      int          exp_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Architectural RV32M result computed with 64-bit integer arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      t  = '0;
      case (f3)
         3'b000: t = ua * ub;
         3'b001: begin t = sa * sb; t = {32'b0, t[63:32]}; end
         3'b010: begin t = sa * longint'(ub); t = {32'b0, t[63:32]}; end
         3'b011: begin t = ua * ub; t = {32'b0, t[63:32]}; end
         3'b100: begin
            if (b == 0) t = 64'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = {32'b0, a};
            else t = sa / sb;
         end
         3'b101: t = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
         3'b110: begin
            if (b == 0) t = {32'b0, a};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = '0;
            else t = sa % sb;
         end
         default: t = (b == 0) ? {32'b0, a} : ua % ub;
      endcase
      return t[31:0];
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Called just after a posedge; issues in that cycle (T) and observes T+1..T+40
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold,
                        output logic [31:0] res, output logic [4:0] rdo, output int done_at,
                        output int done_cnt, output int busy_cnt, output logic [31:0] end_res);
      bus.start_i  = 1'b1;
      bus.funct3_i = f3;
      bus.op_a_i   = a;
      bus.op_b_i   = b;
      bus.rd_i     = rd;
      #1;
      busy_cnt = bus.busy_o ? 1 : 0;
      done_at  = -1;
      done_cnt = 0;
      res      = '0;
      rdo      = '0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k > hold) bus.start_i = 1'b0;
         #1;
         if (bus.busy_o) busy_cnt++;
         if (bus.done_o) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k;
               res     = bus.result_o;
               rdo     = bus.rd_o;
            end
         end
      end
      end_res = bus.result_o;
   endtask

   task automatic run_and_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd, input int hold,
                                input logic [31:0] exp_res, input int exp_done_at, input int exp_busy);
      logic [31:0] res, end_res;
      logic [4:0]  rdo;
      int          done_at, done_cnt, busy_cnt;
      do_op(f3, a, b, rd, hold, res, rdo, done_at, done_cnt, busy_cnt, end_res);
      check({name, ".result"},   64'(res), 64'(exp_res));
      check({name, ".rd"},       64'(rdo), 64'(rd));
      check({name, ".done_at"},  64'(done_at), 64'(exp_done_at));
      check({name, ".done_cnt"}, 64'(done_cnt), 64'd1);
      check({name, ".busy_cnt"}, 64'(busy_cnt), 64'(exp_busy));
      check({name, ".held"},     64'(end_res), 64'(exp_res));
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          flush_done;

      rst          = 1'b1;
      flush        = 1'b0;
      bus.start_i  = 1'b0;
      bus.funct3_i = '0;
      bus.op_a_i   = '0;
      bus.op_b_i   = '0;
      bus.rd_i     = '0;

      vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33, 33});
      vecs.push_back('{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 5'd2,  32'hFFFF_FFFF, 33, 33});
      vecs.push_back('{3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'h0000_0006, 33, 33});
      vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33, 33});
      vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33, 33});
      vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33, 33});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 33, 33});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33, 33});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd9,  32'h0000_0003, 33, 33});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFF, 33, 33});
      vecs.push_back('{3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        33, 33});
      vecs.push_back('{3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         33, 33});
      vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 33, 33});
      vecs.push_back('{3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1,  1});
      vecs.push_back('{3'b110, 32'd5,         32'd0,         5'd15, 32'd5,         1,  1});
      vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1,  1});
      vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1,  1});

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset.busy",   64'(bus.busy_o),   64'd0);
      check("reset.done",   64'(bus.done_o),   64'd0);
      check("reset.result", 64'(bus.result_o), 64'd0);
      check("reset.rd",     64'(bus.rd_o),     64'd0);

      foreach (vecs[i])
         run_and_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 0,
                       vecs[i].exp_res, vecs[i].exp_done_at, vecs[i].exp_busy);

      // start_i held high through DONE must not launch a second op
      run_and_check("hold_mul", 3'b000, 32'd9, 32'd11, 5'd20, 33, 32'd99, 33, 33);
      run_and_check("hold_dz",  3'b111, 32'd77, 32'd0, 5'd21, 1, 32'd77, 1, 1);

      // Flush at T+10 of a DIV: previous result must survive, new op must complete
      run_and_check("pre_flush", 3'b101, 32'd100, 32'd7, 5'd3, 0, 32'd14, 33, 33);
      flush_done   = 0;
      bus.start_i  = 1'b1;
      bus.funct3_i = 3'b100;
      bus.op_a_i   = 32'hFFFF_FFF9;
      bus.op_b_i   = 32'd2;
      bus.rd_i     = 5'd9;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         bus.start_i = 1'b0;
         if (k == 10) flush = 1'b1;
         #1;
         if (bus.done_o) flush_done++;
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      check("flush.busy",     64'(bus.busy_o),   64'd0);
      check("flush.done",     64'(bus.done_o),   64'd0);
      check("flush.result",   64'(bus.result_o), 64'd14);
      check("flush.rd",       64'(bus.rd_o),     64'd3);
      check("flush.no_early", 64'(flush_done),   64'd0);
      run_and_check("after_flush", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 0, 32'hFFFF_FFFD, 33, 33);

      // Reset at T+5 of a MUL clears all outputs the next cycle
      bus.start_i  = 1'b1;
      bus.funct3_i = 3'b000;
      bus.op_a_i   = 32'd3;
      bus.op_b_i   = 32'd5;
      bus.rd_i     = 5'd7;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         bus.start_i = 1'b0;
         if (k == 5) rst = 1'b1;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst.busy",   64'(bus.busy_o),   64'd0);
      check("midrst.done",   64'(bus.done_o),   64'd0);
      check("midrst.result", 64'(bus.result_o), 64'd0);
      check("midrst.rd",     64'(bus.rd_o),     64'd0);
      run_and_check("after_rst", 3'b000, 32'd3, 32'd5, 5'd7, 0, 32'd15, 33, 33);

      for (int n = 0; n < 200; n++) begin
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       a = 32'h0;
            1:       a = 32'hFFFF_FFFF;
            2:       a = 32'h8000_0000;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'h8000_0000;
            default: b = $urandom;
         endcase
         run_and_check($sformatf("rand%0d_f%0d_%h_%h", n, f3, a, b), f3, a, b,
                       5'($urandom_range(0, 31)), 0, ref_model(f3, a, b),
                       is_special(f3, a, b) ? 1 : 33, is_special(f3, a, b) ? 1 : 33);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
